// File: rtl/key_ctrl_pkg.sv
// Shared types and constants for the key event controller: FSM states,
// the queued event record and the reset-time key map.
package key_ctrl_pkg;

   localparam int DEF_NUM_KEYS   = 8;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int IDX_W          = 3;
   localparam int CODE_W         = 9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MATCH  = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             press;
   } key_evt_t;

   // Default map: shifts, space, enter, then the extended arrow keys
   function automatic logic [CODE_W-1:0] default_code(input logic [IDX_W-1:0] i);
      logic [CODE_W-1:0] c;
      case (i)
         3'd0:    c = 9'h012;
         3'd1:    c = 9'h059;
         3'd2:    c = 9'h029;
         3'd3:    c = 9'h05A;
         3'd4:    c = 9'h16B;
         3'd5:    c = 9'h174;
         3'd6:    c = 9'h175;
         default: c = 9'h172;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Small event queue; head is read straight from registered storage so the
// consumer sees it combinationally. Depth must be a power of two.
module key_evt_fifo
   import key_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  key_evt_t push_data,
   input  logic     pop,
   output logic     full,
   output logic     empty,
   output key_evt_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   key_evt_t      mem_q [DEPTH];
   key_evt_t      mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   always_comb begin
      empty    = (cnt_q == '0);
      full     = (cnt_q == FULL_CNT);
      head     = mem_q[rd_ptr_q];
      pop_ok   = pop && !empty;
      // A pop in the same cycle frees the slot a full queue needs
      push_ok  = push && (!full || pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/key_event_ctrl.sv
// Maps keyboard make/break codes onto game-key indices, tracks held keys
// and queues press/release events for a downstream consumer.
module key_event_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int NUM_KEYS   = DEF_NUM_KEYS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [8:0]          key_code,
   input  logic                make,
   input  logic                breakk,
   input  logic                cfg_we,
   input  logic [2:0]          cfg_idx,
   input  logic [8:0]          cfg_code,
   output logic [NUM_KEYS-1:0] key_down,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [2:0]          evt_idx,
   output logic                evt_press,
   output logic                overflow,
   input  logic                clr_ovf
);

   state_t              state_q, state_d;
   logic [CODE_W-1:0]   map_q [NUM_KEYS];
   logic [CODE_W-1:0]   map_d [NUM_KEYS];
   logic [NUM_KEYS-1:0] key_down_q, key_down_d;
   logic                ovf_q, ovf_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                press_q, press_d;
   logic                hit_q, hit_d;
   logic [IDX_W-1:0]    idx_q, idx_d;

   logic     pulse, push, pop, fifo_full, fifo_empty;
   key_evt_t push_evt, head_evt;

   key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_evt),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head_evt)
   );

   assign evt_valid = !fifo_empty;
   assign evt_idx   = fifo_empty ? '0 : head_evt.idx;
   assign evt_press = fifo_empty ? 1'b0 : head_evt.press;
   assign pop       = evt_valid && evt_ready;
   assign key_down  = key_down_q;
   assign overflow  = ovf_q;

   always_comb begin
      pulse      = make ^ breakk;
      state_d    = state_q;
      map_d      = map_q;
      key_down_d = key_down_q;
      ovf_d      = ovf_q;
      code_d     = code_q;
      press_d    = press_q;
      hit_d      = hit_q;
      idx_d      = idx_q;
      push       = 1'b0;
      push_evt   = '{idx: idx_q, press: press_q};

      case (state_q)
         ST_IDLE: begin
            if (pulse) begin
               code_d  = key_code;
               press_d = make;
               state_d = ST_MATCH;
            end
         end
         ST_MATCH: begin
            hit_d = 1'b0;
            idx_d = '0;
            // Descending scan so the lowest enabled match is the last to win
            for (int i = NUM_KEYS-1; i >= 0; i--) begin
               if (map_q[i] != '0 && map_q[i] == code_q) begin
                  hit_d = 1'b1;
                  idx_d = i[IDX_W-1:0];
               end
            end
            state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            if (hit_q && (key_down_q[idx_q] != press_q)) begin
               key_down_d[idx_q] = press_q;
               push              = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (clr_ovf) ovf_d = 1'b0;
      if (state_q != ST_IDLE && pulse) ovf_d = 1'b1;
      if (push && fifo_full && !pop) ovf_d = 1'b1;

      // Remapping a key forgets its held state silently
      if (cfg_we) begin
         map_d[cfg_idx]      = cfg_code;
         key_down_d[cfg_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         key_down_q <= '0;
         ovf_q      <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            map_q[i] <= default_code(i[IDX_W-1:0]);
         end
      end else begin
         state_q    <= state_d;
         key_down_q <= key_down_d;
         ovf_q      <= ovf_d;
         map_q      <= map_d;
      end
   end

   always_ff @(posedge clk) begin
      code_q  <= code_d;
      press_q <= press_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
   end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a queue-based event scoreboard.
module tb_key_event_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] key_code;
   logic       make, breakk;
   logic       cfg_we;
   logic [2:0] cfg_idx;
   logic [8:0] cfg_code;
   logic [7:0] key_down;
   logic       evt_valid, evt_ready;
   logic [2:0] evt_idx;
   logic       evt_press;
   logic       overflow, clr_ovf;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] exp_q[$];

   key_event_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .key_code  (key_code),
      .make      (make),
      .breakk    (breakk),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_code  (cfg_code),
      .key_down  (key_down),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_idx   (evt_idx),
      .evt_press (evt_press),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pulse(input logic [8:0] c, input logic is_make);
      key_code = c;
      make     = is_make;
      breakk   = !is_make;
      tick();
      make     = 1'b0;
      breakk   = 1'b0;
   endtask

   // Issue one key op and leave the bench in cycle N+3 with the FSM idle
   task automatic key_op(input logic [8:0] c, input logic is_make,
                         input logic has_evt, input logic [2:0] idx);
      if (has_evt) exp_q.push_back({idx, is_make});
      pulse(c, is_make);
      tick();
      tick();
   endtask

   // Scoreboard monitor: every accepted head event must match the oldest expectation
   always @(negedge clk) begin
      if (!reset && evt_valid && evt_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL evt_unexpected: got idx=%0d press=%0b expected none", evt_idx, evt_press);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if ({evt_idx, evt_press} !== e) begin
               n_fail++;
               $display("FAIL evt_order: got idx=%0d press=%0b expected idx=%0d press=%0b",
                        evt_idx, evt_press, e[3:1], e[0]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; key_code = '0; make = 0; breakk = 0;
      cfg_we = 0; cfg_idx = '0; cfg_code = '0; evt_ready = 1'b1; clr_ovf = 0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_key_down", key_down, 8'h00);
      check("rst_evt_valid", evt_valid, 0);
      check("rst_evt_idx", evt_idx, 0);
      check("rst_evt_press", evt_press, 0);
      check("rst_overflow", overflow, 0);

      // Press L-shift with explicit latency checks
      exp_q.push_back({3'd0, 1'b1});
      pulse(9'h012, 1'b1);
      tick();
      check("lat_n2_valid", evt_valid, 0);
      check("lat_n2_key_down", key_down, 8'h00);
      tick();
      check("lat_n3_valid", evt_valid, 1);
      check("lat_n3_key_down", key_down, 8'h01);
      key_op(9'h012, 1'b0, 1'b1, 3'd0);
      check("release_key_down", key_down, 8'h00);
      key_op(9'h012, 1'b0, 1'b0, 3'd0);
      check("stray_break_key_down", key_down, 8'h00);

      // Auto-repeat: three makes give one event
      key_op(9'h059, 1'b1, 1'b1, 3'd1);
      key_op(9'h059, 1'b1, 1'b0, 3'd1);
      key_op(9'h059, 1'b1, 1'b0, 3'd1);
      check("repeat_key_down", key_down, 8'h02);
      key_op(9'h059, 1'b0, 1'b1, 3'd1);
      check("repeat_release", key_down, 8'h00);

      // Both strobes high is ignored entirely
      key_code = 9'h012; make = 1; breakk = 1;
      tick();
      make = 0; breakk = 0;
      tick(); tick();
      check("both_key_down", key_down, 8'h00);
      check("both_overflow", overflow, 0);

      // Queue fill with consumer stalled
      evt_ready = 1'b0;
      key_op(9'h012, 1'b1, 1'b1, 3'd0);
      key_op(9'h059, 1'b1, 1'b1, 3'd1);
      key_op(9'h029, 1'b1, 1'b1, 3'd2);
      key_op(9'h05A, 1'b1, 1'b1, 3'd3);
      check("fill4_overflow", overflow, 0);
      key_op(9'h16B, 1'b1, 1'b0, 3'd4);
      check("full_overflow", overflow, 1);
      check("full_key_down", key_down, 8'h1F);
      check("full_head_idx", evt_idx, 0);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("clr_overflow", overflow, 0);
      evt_ready = 1'b1;
      repeat (6) tick();
      check("drain_valid", evt_valid, 0);
      for (int k = 0; k < 5; k++) begin
         logic [8:0] codes [5];
         codes = '{9'h012, 9'h059, 9'h029, 9'h05A, 9'h16B};
         key_op(codes[k], 1'b0, 1'b1, 3'(k));
      end
      check("all_released", key_down, 8'h00);

      // Remap entry 2 to 9'h01C
      cfg_we = 1'b1; cfg_idx = 3'd2; cfg_code = 9'h01C;
      tick();
      cfg_we = 1'b0;
      key_op(9'h029, 1'b1, 1'b0, 3'd2);
      check("old_code_key_down", key_down, 8'h00);
      key_op(9'h01C, 1'b1, 1'b1, 3'd2);
      check("new_code_key_down", key_down, 8'h04);
      key_op(9'h01C, 1'b0, 1'b1, 3'd2);

      // Second make while busy is dropped
      exp_q.push_back({3'd3, 1'b1});
      pulse(9'h05A, 1'b1);
      pulse(9'h16B, 1'b1);
      tick();
      check("busy_overflow", overflow, 1);
      check("busy_key_down", key_down, 8'h08);
      tick();

      // Reset during ST_UPDATE aborts the event and restores the map
      pulse(9'h174, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_key_down", key_down, 8'h00);
      check("midrst_valid", evt_valid, 0);
      check("midrst_overflow", overflow, 0);
      repeat (3) tick();
      check("midrst_no_evt", evt_valid, 0);
      key_op(9'h029, 1'b1, 1'b1, 3'd2);
      check("default_map_key_down", key_down, 8'h04);
      key_op(9'h01C, 1'b1, 1'b0, 3'd2);
      check("remap_gone_key_down", key_down, 8'h04);

      repeat (4) tick();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 8, number of tracked game keys (index width 3).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event queue depth (power of two).
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port key_code  in  9  {extended, scan byte} from keyboard byte recognizer.
REQ-006 SHALL have port make  in  1  one-cycle pulse, key_code valid as press.
REQ-007 SHALL have port breakk  in  1  one-cycle pulse, key_code valid as release.
REQ-008 SHALL have port cfg_we  in  1  write one key-map entry.
REQ-009 SHALL have port cfg_idx  in  3  key-map entry index.
REQ-010 SHALL have port cfg_code  in  9  key code for entry; 9'h000 disables entry.
REQ-011 SHALL have port key_down  out  NUM_KEYS  level, bit i set while mapped key i is held.
REQ-012 SHALL have port evt_valid  out  1  queue head valid.
REQ-013 SHALL have port evt_ready  in  1  consumer accepts head when evt_valid high.
REQ-014 SHALL have port evt_idx  out  3  key index of head event.
REQ-015 SHALL have port evt_press  out  1  1 = press, 0 = release (head event).
REQ-016 SHALL have port overflow  out  1  sticky lost-event flag.
REQ-017 SHALL have port clr_ovf  in  1  clears overflow.

Function
REQ-018 SHALL run FSM ST_IDLE -> ST_MATCH -> ST_UPDATE -> ST_IDLE; leave ST_IDLE only on make xor breakk, capturing key_code and polarity.
REQ-019 SHALL ignore cycles with make and breakk both high (no capture, no flag).
REQ-020 SHALL, in ST_MATCH, compare captured code against all enabled map entries; lowest matching index wins; register hit and index.
REQ-021 SHALL, in ST_UPDATE, on hit: set key_down[idx] for press, clear it for release; push event {idx, press} only if the bit changed (auto-repeat makes and stray breaks produce no event).
REQ-022 SHALL produce no state change on a miss.
REQ-023 SHALL give latency: pulse in cycle N -> key_down updated and evt_valid high from cycle N+3 when queue was empty.
REQ-024 SHALL drop any make/breakk pulse arriving while FSM not in ST_IDLE and set overflow.
REQ-025 SHALL, when queue full in ST_UPDATE, still update key_down, drop the event, set overflow; a same-cycle pop (evt_valid&evt_ready) frees a slot and the push succeeds.
REQ-026 SHALL present queue head combinationally from registered FIFO storage; pop on evt_valid&evt_ready; FIFO order preserved, pointers wrap modulo FIFO_DEPTH.
REQ-027 SHALL clear overflow on clr_ovf; a set condition in the same cycle wins.
REQ-028 SHALL apply cfg_we at the next edge; the written entry's key_down bit clears with no event; a write coinciding with ST_MATCH uses the old entry value for that match.

Reset
REQ-029 SHALL on reset: FSM ST_IDLE, key_down 0, queue empty (evt_valid 0, evt_idx 0, evt_press 0), overflow 0.
REQ-030 SHALL on reset load the key map with defaults: 0:9'h012 (L-shift), 1:9'h059 (R-shift), 2:9'h029 (space), 3:9'h05A (enter), 4:9'h16B (left), 5:9'h174 (right), 6:9'h175 (up), 7:9'h172 (down).
REQ-031 SHALL abort any in-flight event on reset mid-operation; no event emitted afterwards.

Structure
REQ-032 SHALL place the state enum, NUM_KEYS, FIFO_DEPTH default, event struct {idx, press} and the default key-map table in shared package key_ctrl_pkg.
REQ-033 SHALL implement the queue as sub-module key_evt_fifo (parameterised depth, push/pop, full/empty).

Verification
REQ-034 SHALL cover: make 9'h012 -> key_down=8'h01 and event {0,1} at N+3; breakk 9'h012 -> key_down=0, event {0,0}.
REQ-035 SHALL cover: three makes 9'h059 without break -> exactly one event {1,1}; key_down[1] stays 1.
REQ-036 SHALL cover: evt_ready held 0, five distinct press events -> four queued in order, fifth dropped, overflow=1, key_down=8'h1F; clr_ovf -> overflow=0.
REQ-037 SHALL cover: cfg_we idx 2 code 9'h01C, then make 9'h029 -> no event; make 9'h01C -> event {2,1}.
REQ-038 SHALL cover: make pulse one cycle after a prior make -> second dropped, overflow=1; reset asserted in ST_UPDATE -> key_down=0, evt_valid=0, map back to defaults.
